// File: rtl/spi_master_arb.sv
// spi_master_arb: round-robin arbiter sharing one spi_master among N_REQ requesters, one burst per grant
// Define SPI_ARB_TIMEOUT_EN to add a WAIT watchdog that aborts the burst with an err pulse after TMO_CYC cycles.
module spi_master_arb #(
  parameter int N_REQ    = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int START_W  = 2,
  parameter int TMO_CYC  = 256
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     last,
  input  logic [8*N_REQ-1:0]   txd,
  input  logic [N_REQ-1:0]     mlb_i,
  input  logic [2*N_REQ-1:0]   cdiv_i,
  output logic [N_REQ-1:0]     ack,
  output logic [7:0]           rxd,
  output logic [N_REQ-1:0]     cs_n,
  output logic                 busy,
  output logic                 err,
  output logic                 m_start,
  output logic [7:0]           m_tdat,
  output logic                 m_mlb,
  output logic [1:0]           m_cdiv,
  input  logic                 m_done,
  input  logic [7:0]           m_rdata
);
  localparam int OW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int M1 = CS_SETUP > CS_HOLD ? CS_SETUP : CS_HOLD;
  localparam int M2 = START_W > TMO_CYC ? START_W : TMO_CYC;
  localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, ACK, NEXT, HOLD} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [OW-1:0] owner, owner_d, rr, rr_d, gnt, rr_nx;
  logic last_l, last_d, done_q, found, busy_d, err_d, start_d, mlb_d;
  logic [N_REQ-1:0] ack_d, cs_d;
  logic [7:0] rxd_d, tdat_d;
  logic [1:0] cdiv_d;
  always_comb begin
    state_d = state;
    owner_d = owner;
    rr_d    = rr;
    last_d  = last_l;
    ack_d   = '0;
    rxd_d   = rxd;
    cs_d    = cs_n;
    busy_d  = busy;
    err_d   = 1'b0;
    start_d = m_start;
    tdat_d  = m_tdat;
    mlb_d   = m_mlb;
    cdiv_d  = m_cdiv;
    found   = 1'b0;
    gnt     = '0;
    rr_nx   = owner == OW'(N_REQ-1) ? '0 : owner + 1'b1;
    for (int k = 0; k < N_REQ; k++)
      if (!found && req[(int'(rr)+k) % N_REQ]) begin
        found = 1'b1;
        gnt   = OW'((int'(rr)+k) % N_REQ);
      end
    case (state)
      IDLE: if (found) begin
        state_d = SETUP;
        owner_d = gnt;
        mlb_d   = mlb_i[gnt];
        cdiv_d  = cdiv_i[2*gnt +: 2];
        cs_d    = ~(N_REQ'(1) << gnt);
        busy_d  = 1'b1;
      end
      SETUP: if (cnt == CW'(CS_SETUP-1)) state_d = START;
      START: begin
        if (cnt == '0) begin
          tdat_d = txd[8*owner +: 8];
          last_d = last[owner];
        end
        start_d = cnt != CW'(START_W);
        if (cnt == CW'(START_W)) state_d = WAIT;
      end
      WAIT: if (m_done && !done_q) begin
        state_d      = ACK;
        rxd_d        = m_rdata;
        ack_d[owner] = 1'b1;
      end
`ifdef SPI_ARB_TIMEOUT_EN
      else if (cnt == CW'(TMO_CYC-1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
        cs_d    = '1;
        busy_d  = 1'b0;
        rr_d    = rr_nx;
      end
`endif
      ACK:  state_d = last_l ? HOLD : NEXT;
      NEXT: if (req[owner]) state_d = START;
      HOLD: if (cnt == CW'(CS_HOLD-1)) begin
        state_d = IDLE;
        cs_d    = '1;
        busy_d  = 1'b0;
        rr_d    = rr_nx;
      end
      default: state_d = IDLE;
    endcase
    // every state's counter restarts from zero on entry
    cnt_d = state_d != state ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      state   <= IDLE;
      cnt     <= '0;
      owner   <= '0;
      rr      <= '0;
      last_l  <= 1'b0;
      done_q  <= 1'b0;
      ack     <= '0;
      rxd     <= '0;
      cs_n    <= '1;
      busy    <= 1'b0;
      err     <= 1'b0;
      m_start <= 1'b0;
      m_tdat  <= '0;
      m_mlb   <= 1'b0;
      m_cdiv  <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      owner   <= owner_d;
      rr      <= rr_d;
      last_l  <= last_d;
      done_q  <= m_done;
      ack     <= ack_d;
      rxd     <= rxd_d;
      cs_n    <= cs_d;
      busy    <= busy_d;
      err     <= err_d;
      m_start <= start_d;
      m_tdat  <= tdat_d;
      m_mlb   <= mlb_d;
      m_cdiv  <= cdiv_d;
    end
endmodule

// File: tb/tb_spi_master_arb.sv
// tb_spi_master_arb: directed bench with a loopback spi_master model and an ack/rxd scoreboard
module tb_spi_master_arb;
  logic clk = 0, rstb = 0, m_done = 0, hang = 0, st_q = 0;
  logic [1:0] req = 0, last = 0, mlb_i = 0, ack, cs_n, ecs;
  logic [15:0] txd = 0;
  logic [3:0] cdiv_i = 0;
  logic [7:0] rxd, m_tdat, m_rdata = 0;
  logic busy, err, m_start, m_mlb;
  logic [1:0] m_cdiv;
  logic [9:0] sb[$];
  logic [9:0] e;
  int compared = 0, mism = 0, exp_rr = 0, cd = 0, n;

  spi_master_arb #(.N_REQ(2), .CS_SETUP(2), .CS_HOLD(2), .START_W(2), .TMO_CYC(16)) dut (
    .clk(clk), .rstb(rstb), .req(req), .last(last), .txd(txd), .mlb_i(mlb_i), .cdiv_i(cdiv_i),
    .ack(ack), .rxd(rxd), .cs_n(cs_n), .busy(busy), .err(err), .m_start(m_start), .m_tdat(m_tdat),
    .m_mlb(m_mlb), .m_cdiv(m_cdiv), .m_done(m_done), .m_rdata(m_rdata));

  always #5 clk = ~clk;

  // loopback spi_master: done pulse with rdata = tdat a few cycles after start rises
  always @(posedge clk) begin
    st_q   <= m_start;
    m_done <= 1'b0;
    if (!rstb) cd <= 0;
    else if (m_start && !st_q && !hang) cd <= 6;
    else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        m_done  <= 1'b1;
        m_rdata <= m_tdat;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rstb) begin
    chk("cs_onehot", 32'($countones(~cs_n) <= 1), 1);
    if (ack != 0) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(ack), 0);
      else begin
        e   = sb.pop_front();
        ecs = ~(2'b01 << e[9:8]);
        chk("ack_owner", 32'(ack), 32'(1) << e[9:8]);
        chk("rxd", 32'(rxd), 32'(e[7:0]));
        chk("ack_cs", 32'(cs_n), 32'(ecs));
      end
    end
  end

  task automatic wait_ack(input int id);
    int k = 0;
    do begin @(negedge clk); k++; end while (!ack[id] && k < 400);
    chk("ack_seen", 32'(ack[id]), 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || cs_n != 2'b11) && k < 400) begin @(negedge clk); k++; end
    chk("idle", 32'({busy, cs_n}), 32'b011);
  endtask

  task automatic xfer(input int id, input logic [7:0] d, input logic l, input int gap);
    txd[8*id +: 8] = d;
    last[id] = l;
    req[id] = 1'b1;
    sb.push_back({2'(id), d});
    wait_ack(id);
    if (l || gap > 0) begin
      req[id] = 1'b0;
      repeat (gap) @(negedge clk);
    end
    if (l) exp_rr = (id + 1) % 2;
  endtask

  task automatic pair();
    int f = exp_rr, s = 1 - exp_rr;
    txd = 16'hC33C;
    last = 2'b11;
    req = 2'b11;
    sb.push_back({2'(f), txd[8*f +: 8]});
    sb.push_back({2'(s), txd[8*s +: 8]});
    wait_ack(f);
    req[f] = 1'b0;
    wait_ack(s);
    req[s] = 1'b0;
    exp_rr = (s + 1) % 2;
    wait_idle();
  endtask

  initial begin
    req = 2'b01; last = 2'b01; txd = 16'h0055;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'b11);
    chk("rst_m_start", 32'(m_start), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_m_tdat", 32'(m_tdat), 0);
    sb.push_back({2'd0, 8'h55});
    rstb = 1;
    @(negedge clk);
    chk("grant0_cs", 32'(cs_n), 32'b10);
    chk("grant0_busy", 32'(busy), 1);
    n = 0;
    while (!m_start && n < 20) begin @(negedge clk); n++; end
    chk("setup_lat", n, 3);
    chk("m_tdat0", 32'(m_tdat), 32'h55);
    chk("m_mlb0", 32'(m_mlb), 0);
    chk("m_cdiv0", 32'(m_cdiv), 0);
    n = 0;
    while (m_start && n < 20) begin @(negedge clk); n++; end
    chk("start_w", n, 2);
    wait_ack(0);
    req[0] = 1'b0;
    exp_rr = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cs_n[0] && n < 20);
    chk("hold_lat", n, 3);
    chk("hold_busy", 32'(busy), 0);
    mlb_i = 2'b10; cdiv_i = 4'b0100;
    xfer(1, 8'hAA, 1'b0, 2);
    chk("burst_gap_cs", 32'(cs_n), 32'b01);
    chk("burst_cdiv", 32'(m_cdiv), 1);
    xfer(1, 8'h0F, 1'b0, 0);
    chk("burst_mlb", 32'(m_mlb), 1);
    xfer(1, 8'hF0, 1'b1, 0);
    chk("burst_cdiv_end", 32'(m_cdiv), 1);
    wait_idle();
    pair();
    xfer(0, 8'h5A, 1'b1, 0);
    wait_idle();
    pair();
    txd[7:0] = 8'h11; last[0] = 1'b0; req[0] = 1'b1;
    sb.push_back({2'd0, 8'h11});
    repeat (3) @(negedge clk);
    txd[15:8] = 8'h22; last[1] = 1'b1; req[1] = 1'b1;
    wait_ack(0);
    req[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("pause_cs", 32'(cs_n), 32'b10);
    chk("pause_busy", 32'(busy), 1);
    chk("pause_tdat", 32'(m_tdat), 32'h11);
    sb.push_back({2'd0, 8'h33});
    txd[7:0] = 8'h33; last[0] = 1'b1; req[0] = 1'b1;
    sb.push_back({2'd1, 8'h22});
    wait_ack(0);
    req[0] = 1'b0;
    chk("pause_end_cs", 32'(cs_n), 32'b10);
    wait_ack(1);
    req[1] = 1'b0;
    exp_rr = 0;
    wait_idle();
`ifdef SPI_ARB_TIMEOUT_EN
    hang = 1;
    txd[7:0] = 8'h99; last[0] = 1'b1; req[0] = 1'b1;
    n = 0;
    while (!m_start && n < 40) begin @(negedge clk); n++; end
    while (m_start && n < 40) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!err && n < 40);
    req[0] = 1'b0;
    chk("tmo_lat", n, 16);
    chk("tmo_ack", 32'(ack), 0);
    chk("tmo_cs", 32'(cs_n), 32'b11);
    chk("tmo_busy", 32'(busy), 0);
    @(negedge clk);
    chk("tmo_err_pulse", 32'(err), 0);
    exp_rr = 1;
    hang = 0;
`endif
    hang = 1;
    txd[7:0] = 8'h77; last[0] = 1'b1; req[0] = 1'b1;
    n = 0;
    while (!m_start && n < 40) begin @(negedge clk); n++; end
    while (m_start && n < 40) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rstb = 0;
    #1;
    chk("midrst_cs", 32'(cs_n), 32'b11);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_tdat", 32'(m_tdat), 0);
    chk("midrst_rxd", 32'(rxd), 0);
    chk("midrst_ack", 32'(ack), 0);
    req = 0; hang = 0;
    @(negedge clk);
    rstb = 1;
    exp_rr = 0;
    xfer(1, 8'h3C, 1'b1, 0);
    wait_idle();
    pair();
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
